// File: rtl/dmem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the two requester ports and the memory-side bus of the data-memory
// arbiter.
//   Port A : a_req/a_we/a_funct3/a_addr/a_wdata in, a_gnt/a_rvalid/a_rdata/a_err out
//   Port B : b_req/b_we/b_addr/b_wdata in, b_gnt/b_rvalid/b_rdata out
//   Memory : mem_en/mem_we/mem_be/mem_addr/mem_wdata out, mem_rdata in
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding system, which holds the requesters and the memory.
// ----------------------------------------------------------------------------
interface dmem_port_arbiter_if;
   logic        a_req;
   logic        a_we;
   logic [2:0]  a_funct3;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic        a_gnt;
   logic        a_rvalid;
   logic [31:0] a_rdata;
   logic        a_err;

   logic        b_req;
   logic        b_we;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_gnt;
   logic        b_rvalid;
   logic [31:0] b_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  a_req, a_we, a_funct3, a_addr, a_wdata,
      output a_gnt, a_rvalid, a_rdata, a_err,
      input  b_req, b_we, b_addr, b_wdata,
      output b_gnt, b_rvalid, b_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output a_req, a_we, a_funct3, a_addr, a_wdata,
      input  a_gnt, a_rvalid, a_rdata, a_err,
      output b_req, b_we, b_addr, b_wdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares a single-port synchronous data memory between the core load/store
// path (port A) and the debug/loader word port (port B). It converts RV32I
// byte/half/word accesses into word-aligned memory transactions.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : dmem_port_arbiter_if.slave (both requester ports plus memory bus)
// Parameter STARVE_MAX (1..15): the number of consecutive refusals of port B
// after which B takes priority over A.
// ----------------------------------------------------------------------------
module dmem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   dmem_port_arbiter_if.slave bus
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   // Response tag: one entry covers the single access in flight.
   // owner = 1 marks port B. we marks a store, whose acknowledge returns zero data.
   typedef struct packed {
      logic       valid;
      logic       owner;
      logic       err;
      logic       we;
      logic [2:0] funct3;
      logic [1:0] off;
   } tag_t;

   tag_t       tag_q, tag_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;

   logic aReq, bReq;
   logic aGnt, bGnt;
   logic aErr;
   logic starved;

   // Requests are masked while reset is asserted. This keeps grants and the
   // memory strobe quiet during reset.
   assign aReq = bus.a_req & rst_n;
   assign bReq = bus.b_req & rst_n;

   // Port A wins by default. B overrides once it has been refused STARVE_MAX times.
   assign starved = (wait_cnt_q == STARVE_LIM);
   assign bGnt    = bReq & (~aReq | starved);
   assign aGnt    = aReq & ~bGnt;

   assign bus.a_gnt = aGnt;
   assign bus.b_gnt = bGnt;

   // Port A alignment and funct3 legality check.
   always_comb begin
      aErr = 1'b0;
      unique case (bus.a_funct3)
         3'b000, 3'b100: aErr = 1'b0;
         3'b001, 3'b101: aErr = bus.a_addr[0];
         3'b010:         aErr = (bus.a_addr[1:0] != 2'b00);
         default:        aErr = 1'b1;
      endcase
   end

   // Memory-side drive. A rejected (misaligned) A access is still granted,
   // but it never reaches the memory.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = 4'b0000;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      if (bGnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.b_we;
         bus.mem_be    = 4'b1111;
         bus.mem_addr  = {bus.b_addr[31:2], 2'b00};
         bus.mem_wdata = bus.b_we ? bus.b_wdata : 32'h0;
      end else if (aGnt && !aErr) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = bus.a_we;
         bus.mem_addr = {bus.a_addr[31:2], 2'b00};
         bus.mem_be   = 4'b1111;
         if (bus.a_we) begin
            unique case (bus.a_funct3[1:0])
               2'b00: begin
                  bus.mem_be    = 4'b0001 << bus.a_addr[1:0];
                  bus.mem_wdata = {4{bus.a_wdata[7:0]}};
               end
               2'b01: begin
                  bus.mem_be    = bus.a_addr[1] ? 4'b1100 : 4'b0011;
                  bus.mem_wdata = {2{bus.a_wdata[15:0]}};
               end
               default: begin
                  bus.mem_be    = 4'b1111;
                  bus.mem_wdata = bus.a_wdata;
               end
            endcase
         end
      end
   end

   // Next-state values for the tag and the starvation counter.
   always_comb begin
      tag_d        = '0;
      tag_d.valid  = aGnt | bGnt;
      tag_d.owner  = bGnt;
      tag_d.err    = aGnt & aErr;
      tag_d.we     = bGnt ? bus.b_we : bus.a_we;
      tag_d.funct3 = bGnt ? 3'b010 : bus.a_funct3;
      tag_d.off    = bGnt ? 2'b00 : bus.a_addr[1:0];

      wait_cnt_d = wait_cnt_q;
      if (!bReq || bGnt) begin
         wait_cnt_d = 4'd0;
      end else if (!starved) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   // The tag clears asynchronously, so a pending response disappears as soon
   // as reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q      <= '0;
         wait_cnt_q <= 4'd0;
      end else begin
         tag_q      <= tag_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   logic [7:0]  laneByte;
   logic [15:0] laneHalf;
   logic [31:0] loadData;

   // Lane extraction and extension of the load data, using the tagged byte offset.
   always_comb begin
      laneByte = 8'h0;
      unique case (tag_q.off)
         2'b00: laneByte = bus.mem_rdata[7:0];
         2'b01: laneByte = bus.mem_rdata[15:8];
         2'b10: laneByte = bus.mem_rdata[23:16];
         2'b11: laneByte = bus.mem_rdata[31:24];
      endcase
      laneHalf = tag_q.off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      loadData = bus.mem_rdata;
      unique case (tag_q.funct3)
         3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
         3'b100:  loadData = {24'h0, laneByte};
         3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
         3'b101:  loadData = {16'h0, laneHalf};
         default: loadData = bus.mem_rdata;
      endcase
   end

   assign bus.a_rvalid = tag_q.valid & ~tag_q.owner;
   assign bus.a_err    = bus.a_rvalid & tag_q.err;
   assign bus.a_rdata  = (bus.a_rvalid && !tag_q.err && !tag_q.we) ? loadData : 32'h0;

   assign bus.b_rvalid = tag_q.valid & tag_q.owner;
   assign bus.b_rdata  = (bus.b_rvalid && !tag_q.we) ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed self-checking bench for dmem_port_arbiter. It provides a small
// synchronous word memory behind the arbiter. Expected responses are queued
// when an access is granted, and they are compared when the response cycle
// arrives.
// ----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   exp_t sbQ[$];

   logic [31:0] memArr [0:255];
   logic [31:0] rdataQ;

   dmem_port_arbiter_if bus ();

   dmem_port_arbiter #(.STARVE_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port synchronous memory. Read data appears one cycle after mem_en.
   assign bus.mem_rdata = rdataQ;
   initial begin
      for (int i = 0; i < 256; i++) memArr[i] = 32'h0;
      rdataQ = 32'h0;
   end
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            for (int l = 0; l < 4; l++) begin
               if (bus.mem_be[l]) memArr[bus.mem_addr[9:2]][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
            end
         end else begin
            rdataQ <= memArr[bus.mem_addr[9:2]];
         end
      end
   end

   // Single comparison point. A mismatch is counted and reported.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Drive a request onto one port (port 0 = A, port 1 = B).
   task automatic applyStimulus(input logic port, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
      end else begin
         bus.a_req = 1'b1; bus.a_we = we; bus.a_funct3 = f3; bus.a_addr = addr; bus.a_wdata = wdata;
      end
   endtask

   task automatic idleInputs();
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_funct3 = 3'b010; bus.a_addr = 32'h0; bus.a_wdata = 32'h0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 32'h0; bus.b_wdata = 32'h0;
   endtask

   // Pop the oldest expected response and compare it with what the DUT shows now.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL %s observed=unexpected_check expected=queued_response", tag);
      end else begin
         e = sbQ.pop_front();
         if (e.port) begin
            chk({tag, "_b_rvalid"}, 32'(bus.b_rvalid), 32'd1);
            chk({tag, "_b_rdata"},  bus.b_rdata,       e.data);
            chk({tag, "_a_rvalid"}, 32'(bus.a_rvalid), 32'd0);
         end else begin
            chk({tag, "_a_rvalid"}, 32'(bus.a_rvalid), 32'd1);
            chk({tag, "_a_err"},    32'(bus.a_err),    32'(e.err));
            chk({tag, "_a_rdata"},  bus.a_rdata,       e.data);
            chk({tag, "_b_rvalid"}, 32'(bus.b_rvalid), 32'd0);
         end
      end
   endtask

   // One isolated access: the grant is checked in the request cycle and the
   // response exactly one cycle later.
   task automatic access(input string tag, input logic port, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic expErr, input logic [31:0] expData,
                         input logic [3:0] expBe, input logic [31:0] expWdata);
      exp_t e;
      @(posedge clk); #1;
      applyStimulus(port, we, f3, addr, wdata);
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(port ? bus.b_gnt : bus.a_gnt), 32'd1);
      chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'(!expErr));
      if (!expErr) begin
         chk({tag, "_mem_be"},   32'(bus.mem_be), 32'(expBe));
         chk({tag, "_mem_addr"}, bus.mem_addr,    {addr[31:2], 2'b00});
      end
      if (we && !expErr) chk({tag, "_mem_wdata"}, bus.mem_wdata, expWdata);
      e.port = port; e.err = expErr; e.data = expData;
      sbQ.push_back(e);
      @(posedge clk); #1;
      idleInputs();
      @(negedge clk);
      checkOutput({tag, "_resp"});
   endtask

   initial begin
      exp_t e;
      logic expB;
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      idleInputs();

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_gnt",    32'(bus.a_gnt),    32'd0);
      chk("rst_b_gnt",    32'(bus.b_gnt),    32'd0);
      chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
      chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
      chk("rst_a_err",    32'(bus.a_err),    32'd0);
      chk("rst_mem_en",   32'(bus.mem_en),   32'd0);
      chk("rst_a_rdata",  bus.a_rdata,       32'h0);
      rst_n = 1'b1;

      // Setup through port B, followed by the load-extension checks on port A.
      access("b_sw",  1'b1, 1'b1, 3'b010, 32'h100, 32'h1234ABCD, 1'b0, 32'h0,        4'b1111, 32'h1234ABCD);
      access("lw",    1'b0, 1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'h1234ABCD, 4'b1111, 32'h0);
      access("lh2",   1'b0, 1'b0, 3'b001, 32'h102, 32'h0,        1'b0, 32'h00001234, 4'b1111, 32'h0);
      access("lh0",   1'b0, 1'b0, 3'b001, 32'h100, 32'h0,        1'b0, 32'hFFFFABCD, 4'b1111, 32'h0);
      access("lhu0",  1'b0, 1'b0, 3'b101, 32'h100, 32'h0,        1'b0, 32'h0000ABCD, 4'b1111, 32'h0);
      access("lb2",   1'b0, 1'b0, 3'b000, 32'h102, 32'h0,        1'b0, 32'h00000034, 4'b1111, 32'h0);
      access("lb0",   1'b0, 1'b0, 3'b000, 32'h100, 32'h0,        1'b0, 32'hFFFFFFCD, 4'b1111, 32'h0);
      access("lbu0",  1'b0, 1'b0, 3'b100, 32'h100, 32'h0,        1'b0, 32'h000000CD, 4'b1111, 32'h0);
      access("b_lw",  1'b1, 1'b0, 3'b010, 32'h103, 32'h0,        1'b0, 32'h1234ABCD, 4'b1111, 32'h0);

      // Sub-word stores.
      access("sb1",   1'b0, 1'b1, 3'b000, 32'h101, 32'h000000EE, 1'b0, 32'h0,        4'b0010, 32'hEEEEEEEE);
      access("lw_sb", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'h1234EECD, 4'b1111, 32'h0);
      access("sh2",   1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 1'b0, 32'h0,        4'b1100, 32'hBEEFBEEF);
      access("lw_sh", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'hBEEFEECD, 4'b1111, 32'h0);

      // Misaligned and unsupported accesses.
      access("lw_mis", 1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
      access("lh_mis", 1'b0, 1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
      access("f3_011", 1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);

      // Starvation: both ports request continuously. B should win on the 5th cycle.
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) checkOutput($sformatf("starve_resp%0d", i - 1));
         expB = (i == 4);
         chk($sformatf("starve_a_gnt%0d", i), 32'(bus.a_gnt), 32'(!expB));
         chk($sformatf("starve_b_gnt%0d", i), 32'(bus.b_gnt), 32'(expB));
         e.port = expB; e.err = 1'b0; e.data = 32'hBEEFEECD;
         sbQ.push_back(e);
         @(posedge clk); #1;
         if (i == 5) idleInputs();
      end
      @(negedge clk);
      checkOutput("starve_resp5");

      // Reset between a load grant and its response.
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
      @(negedge clk);
      chk("rstmid_gnt", 32'(bus.a_gnt), 32'd1);
      @(posedge clk); #1;
      chk("rstmid_rvalid_pre", 32'(bus.a_rvalid), 32'd1);
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h100, 32'h55AA55AA);
      rst_n = 1'b0;
      #1;
      chk("rstmid_rvalid_drop", 32'(bus.a_rvalid), 32'd0);
      chk("rstmid_a_gnt",       32'(bus.a_gnt),    32'd0);
      chk("rstmid_mem_en",      32'(bus.mem_en),   32'd0);
      chk("rstmid_mem_we",      32'(bus.mem_we),   32'd0);
      chk("rstmid_mem_be",      32'(bus.mem_be),   32'd0);
      chk("rstmid_mem_addr",    bus.mem_addr,      32'h0);
      chk("rstmid_mem_wdata",   bus.mem_wdata,     32'h0);
      @(negedge clk);
      idleInputs();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("rstpost_a_rvalid%0d", i), 32'(bus.a_rvalid), 32'd0);
      end
      chk("sb_empty", 32'(sbQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
